// File: rtl/seq_shift_add_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the sequential shift-and-add multiplier.
//   state_t   : controller states (IDLE accepts, BUSY iterates, DONE presents)
//   cnt_width : width of the iteration counter for an N-bit operand
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold N-1 (last add) without wrapping;
  // $clog2(N+1) leaves headroom so N itself is also representable.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_fast_adder.sv
// -----------------------------------------------------------------------------
// fast_adder
// N-bit carry-lookahead adder: S = A + B + Cin, Cout = carry out of bit N-1.
// Ports:
//   A, B  in  N  addends
//   Cin   in  1  carry in
//   S     out N  sum
//   Cout  out 1  carry out
// Each carry is computed directly from generate/propagate terms as a flat
// sum-of-products rather than rippling through the lower carries.
// -----------------------------------------------------------------------------
module fast_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g    = A & B;
  assign p    = A ^ B;
  assign c[0] = Cin;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_carry
      logic carry_b;

      // c[gi+1] = g[gi] | p[gi]g[gi-1] | ... | p[gi..0]Cin
      always_comb begin : carry_sop
        logic sop;
        logic prop;
        sop  = 1'b0;
        prop = 1'b1;
        for (int j = gi; j >= 0; j--) begin
          sop  = sop | (prop & g[j]);
          prop = prop & p[j];
        end
        carry_b = sop | (prop & Cin);
      end

      assign c[gi+1] = carry_b;
    end
  endgenerate

  assign S    = p ^ c[N-1:0];
  assign Cout = c[N];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
// Iterative unsigned N x N multiplier, one partial product per clock.
// Ports:
//   clk      in   1   clock
//   reset    in   1   synchronous active-high reset
//   i_valid  in   1   operand pair valid
//   i_ready  out  1   operands can be accepted (IDLE only)
//   i_a      in   N   multiplicand
//   i_b      in   N   multiplier
//   o_valid  out  1   o_p holds a finished product (DONE only)
//   o_ready  in   1   consumer takes o_p
//   o_p      out  2N  product; always driven from the accumulator, so it is
//                     only meaningful while o_valid is high
// Accumulator layout: upper half is the running sum, lower half holds the
// multiplier bits not yet consumed. Each BUSY cycle adds mcand (if acc[0]) to
// the upper half and shifts the whole thing right, with the adder carry
// landing in the MSB. After N iterations acc holds the full product.
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [2*N-1:0] o_p
);

  localparam int             CW       = cnt_width(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [2*N-1:0]   acc_q,   acc_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic [N-1:0]     add_s;
  logic             add_cout;

  // Partial-product add: running sum plus mcand gated by the current
  // multiplier LSB.
  assign add_a = acc_q[2*N-1:N];
  assign add_b = acc_q[0] ? mcand_q : '0;

  fast_adder #(
    .N (N)
  ) u_fast_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (1'b0),
    .S    (add_s),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    i_ready = 1'b0;
    o_valid = 1'b0;

    case (state_q)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          mcand_d = i_a;
          acc_d   = {{N{1'b0}}, i_b};
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Carry out becomes the new MSB, so no bit of the sum is lost.
        acc_d = {add_cout, add_s, acc_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        o_valid = 1'b1;
        if (o_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_p = acc_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// Bench for seq_shift_add_multiplier: an N=8 instance for directed and random
// traffic and an N=4 instance for an exhaustive sweep. Inputs are driven on
// the falling edge; outputs are sampled on the falling edge. Expected products
// are plain a*b; a per-instance queue records every accepted pair and is
// matched against every output handshake.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

  localparam int N8 = 8;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic           v8_i_valid, v8_i_ready, v8_o_valid, v8_o_ready;
  logic [N8-1:0]  v8_a, v8_b;
  logic [2*N8-1:0] v8_p;

  logic           v4_i_valid, v4_i_ready, v4_o_valid, v4_o_ready;
  logic [N4-1:0]  v4_a, v4_b;
  logic [2*N4-1:0] v4_p;

  seq_shift_add_multiplier #(.N(N8)) u_dut8 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (v8_i_valid),
    .i_ready (v8_i_ready),
    .i_a     (v8_a),
    .i_b     (v8_b),
    .o_valid (v8_o_valid),
    .o_ready (v8_o_ready),
    .o_p     (v8_p)
  );

  seq_shift_add_multiplier #(.N(N4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (v4_i_valid),
    .i_ready (v4_i_ready),
    .i_a     (v4_a),
    .i_b     (v4_b),
    .o_valid (v4_o_valid),
    .o_ready (v4_o_ready),
    .o_p     (v4_p)
  );

  int checks = 0;
  int errors = 0;

  logic [2*N8-1:0] exp8_q[$];
  logic [2*N4-1:0] exp4_q[$];
  int acc8 = 0, out8 = 0, acc4 = 0, out4 = 0;

  // Scoreboards: sampled just after the falling-edge drive, i.e. the values
  // the next rising edge will see.
  always @(negedge clk) begin
    logic [2*N8-1:0] e8;
    logic [2*N4-1:0] e4;
    #1;
    if (reset) begin
      exp8_q.delete();
      exp4_q.delete();
    end else begin
      if (v8_i_valid && v8_i_ready) begin
        exp8_q.push_back(16'(v8_a) * 16'(v8_b));
        acc8++;
      end
      if (v8_o_valid && v8_o_ready) begin
        out8++;
        checks++;
        if (exp8_q.size() == 0) begin
          errors++;
          $display("FAIL sb8_extra_output got %h required no output", v8_p);
        end else begin
          e8 = exp8_q.pop_front();
          if (v8_p !== e8) begin
            errors++;
            $display("FAIL sb8_product got %h required %h", v8_p, e8);
          end
        end
      end
      if (v4_i_valid && v4_i_ready) begin
        exp4_q.push_back(8'(v4_a) * 8'(v4_b));
        acc4++;
      end
      if (v4_o_valid && v4_o_ready) begin
        out4++;
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL sb4_extra_output got %h required no output", v4_p);
        end else begin
          e4 = exp4_q.pop_front();
          if (v4_p !== e4) begin
            errors++;
            $display("FAIL sb4_product got %h required %h", v4_p, e4);
          end
        end
      end
    end
  end

  // One operation on the N=8 instance. bp = cycles of backpressure after
  // o_valid (bp==0 keeps o_ready high from the start). spam keeps i_valid
  // high with i_a=1 while the block is busy, which must not be accepted.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int bp,
                     input bit spam, input string name);
    int lat;
    bit rdy_leak;
    logic [15:0] expv;
    expv = 16'(a) * 16'(b);
    lat  = 0;
    while (!v8_i_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (v8_i_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready got %b required 1", name, v8_i_ready);
    end
    v8_o_ready = (bp == 0);
    v8_i_valid = 1'b1;
    v8_a       = a;
    v8_b       = b;
    @(negedge clk);
    if (spam) begin
      v8_a = 8'h01;
      v8_b = 8'($urandom_range(0, 255));
    end else begin
      v8_i_valid = 1'b0;
    end
    lat      = 0;
    rdy_leak = 1'b0;
    while (!v8_o_valid && lat < 40) begin
      if (v8_i_ready !== 1'b0) rdy_leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rdy_leak) begin
      errors++;
      $display("FAIL %s_busy_ready got 1 required 0", name);
    end
    // Accept edge, then N BUSY edges; the last one enters DONE.
    checks++;
    if (lat != N8) begin
      errors++;
      $display("FAIL %s_latency got %0d edges required %0d", name, lat, N8);
    end
    checks++;
    if (v8_p !== expv) begin
      errors++;
      $display("FAIL %s_product got %h required %h", name, v8_p, expv);
    end
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      checks++;
      if (v8_o_valid !== 1'b1 || v8_p !== expv || v8_i_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold got v=%b p=%h r=%b required v=1 p=%h r=0",
                 name, v8_o_valid, v8_p, v8_i_ready, expv);
      end
    end
    v8_o_ready = 1'b1;
    v8_i_valid = 1'b0;
    @(negedge clk);
    v8_o_ready = 1'b0;
    checks++;
    if (v8_i_ready !== 1'b1 || v8_o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_handshake got r=%b v=%b required r=1 v=0",
               name, v8_i_ready, v8_o_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (v8_i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_i_ready got %b required 1", v8_i_ready);
    end
    checks++;
    if (v8_o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_o_valid got %b required 0", v8_o_valid);
    end
    checks++;
    if (v8_p !== 16'h0000) begin
      errors++;
      $display("FAIL reset_o_p got %h required 0000", v8_p);
    end
    checks++;
    if (v4_i_ready !== 1'b1 || v4_o_valid !== 1'b0 || v4_p !== 8'h00) begin
      errors++;
      $display("FAIL reset_n4 got r=%b v=%b p=%h required r=1 v=0 p=00",
               v4_i_ready, v4_o_valid, v4_p);
    end
  endtask

  task automatic test_directed();
    op8(8'hFF, 8'hFF, 0, 1'b0, "max");
    op8(8'h00, 8'hAB, 1, 1'b0, "zero_a");
    op8(8'hAB, 8'h00, 0, 1'b0, "zero_b");
    op8(8'h0D, 8'h0B, 0, 1'b0, "d_times_b");
  endtask

  task automatic test_backpressure();
    op8(8'h12, 8'h34, 5, 1'b1, "backpressure");
  endtask

  task automatic test_abort();
    v8_i_valid = 1'b1;
    v8_a       = 8'hC3;
    v8_b       = 8'h5A;
    @(negedge clk);
    v8_i_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (v8_i_ready !== 1'b1 || v8_o_valid !== 1'b0 || v8_p !== 16'h0000) begin
      errors++;
      $display("FAIL abort_state got r=%b v=%b p=%h required r=1 v=0 p=0000",
               v8_i_ready, v8_o_valid, v8_p);
    end
    op8(8'h03, 8'h05, 0, 1'b0, "after_abort");
  endtask

  task automatic test_random_sweep();
    for (int n = 0; n < 1000; n++) begin
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_exhaustive_n4();
    int  lat;
    bit  done;
    logic [7:0] expv;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        expv = 8'(a * b);
        lat  = 0;
        while (!v4_i_ready && lat < 40) begin
          v4_o_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          lat++;
        end
        v4_i_valid = 1'b1;
        v4_a       = 4'(a);
        v4_b       = 4'(b);
        @(negedge clk);
        v4_i_valid = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 60) begin
          v4_o_ready = 1'($urandom_range(0, 1));
          if (v4_o_valid && v4_o_ready) begin
            checks++;
            if (v4_p !== expv) begin
              errors++;
              $display("FAIL n4_product a=%0d b=%0d got %h required %h",
                       a, b, v4_p, expv);
            end
            done = 1'b1;
          end
          @(negedge clk);
          lat++;
        end
        v4_o_ready = 1'b0;
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL n4_timeout a=%0d b=%0d got no output required %h",
                   a, b, expv);
        end
      end
    end
  endtask

  task automatic test_accounting();
    checks++;
    if (exp8_q.size() != 0 || acc8 != out8) begin
      errors++;
      $display("FAIL n8_count got accepted=%0d produced=%0d pending=%0d required equal and 0 pending",
               acc8, out8, exp8_q.size());
    end
    checks++;
    if (exp4_q.size() != 0 || acc4 != out4 || out4 != 256) begin
      errors++;
      $display("FAIL n4_count got accepted=%0d produced=%0d pending=%0d required 256 each",
               acc4, out4, exp4_q.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    v8_i_valid = 1'b0;
    v8_o_ready = 1'b0;
    v8_a       = '0;
    v8_b       = '0;
    v4_i_valid = 1'b0;
    v4_o_ready = 1'b0;
    v4_a       = '0;
    v4_b       = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    // Abort discarded one pending entry via reset; recount from here.
    acc8 = 0;
    out8 = 0;
    test_random_sweep();
    test_exhaustive_n4();
    repeat (2) @(negedge clk);
    test_accounting();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
